// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the AES datapath blocks.
//   byte_t       : one field element
//   GF_POLY_AES  : low byte of x^8+x^4+x^3+x+1 (x^8 implied)
//   xtime()      : multiply one element by x, reducing by the given polynomial
//   gf_state_e   : control states of the multi-cycle multiplier
package aes_gf_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t GF_POLY_AES = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  // Shift left one bit; if x^7 falls off the top, fold the polynomial back in.
  function automatic byte_t xtime(input byte_t v, input byte_t poly);
    byte_t r;
    r = {v[6:0], 1'b0};
    if (v[7]) begin
      r = r ^ poly;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_mult_step.sv
// One lane, one clock worth of shift-and-add GF(2^8) multiplication.
// Consumes BPC multiplier bits, LSB first: for each bit the current
// multiplicand power is conditionally added into the accumulator, then the
// multiplicand is advanced by one power of x.
//   acc         in  8     running partial product
//   ashift      in  8     a * x^i for the next unconsumed bit i
//   bsh         in  BPC   next BPC multiplier bits, bit 0 consumed first
//   acc_next    out 8     accumulator after these BPC bits
//   ashift_next out 8     multiplicand after BPC doublings
module gf_mult_step
  import aes_gf_pkg::*;
#(
  parameter int    BPC  = 1,
  parameter byte_t POLY = GF_POLY_AES
) (
  input  logic [7:0]     acc,
  input  logic [7:0]     ashift,
  input  logic [BPC-1:0] bsh,
  output logic [7:0]     acc_next,
  output logic [7:0]     ashift_next
);

  byte_t acc_s;
  byte_t ash_s;

  // Unrolled chain of BPC conditional-add / xtime stages.
  always_comb begin
    acc_s = acc;
    ash_s = ashift;
    for (int j = 0; j < BPC; j++) begin
      if (bsh[j]) begin
        acc_s = acc_s ^ ash_s;
      end else begin
        acc_s = acc_s;
      end
      ash_s = xtime(ash_s, POLY);
    end
  end

  assign acc_next    = acc_s;
  assign ashift_next = ash_s;

endmodule

// File: rtl/gf_mult_engine.sv
// Multi-lane multi-cycle GF(2^8) multiplier: y_k = a_k * b_k mod (x^8+POLY).
// Accepts one operand set in IDLE, spends 8/BPC cycles in RUN, then presents
// the product in DONE until the consumer takes it. Input and output phases do
// not overlap.
//   clk, reset        clock and synchronous active-high reset
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   a, b              operands, lane k in bits [8k +: 8]
//   out_valid/out_ready result handshake (valid only in DONE)
//   y                 registered products, lane k in bits [8k +: 8]
module gf_mult_engine
  import aes_gf_pkg::*;
#(
  parameter int    LANES = 4,
  parameter int    BPC   = 1,
  parameter byte_t POLY  = GF_POLY_AES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] a,
  input  logic [8*LANES-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] y
);

  localparam int STEPS = 8 / BPC;
  localparam int CW    = $clog2(STEPS) + 1;

  gf_state_e          state_r;
  logic [CW-1:0]      cnt_r;
  byte_t              acc_r      [LANES];
  byte_t              ashift_r   [LANES];
  byte_t              bsh_r      [LANES];
  byte_t              acc_nx_s   [LANES];
  byte_t              ashift_nx_s[LANES];
  logic [8*LANES-1:0] y_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               last_s;

  // Per-lane datapath; lanes never interact.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf_mult_step #(
      .BPC (BPC),
      .POLY(POLY)
    ) u_step (
      .acc        (acc_r[k]),
      .ashift     (ashift_r[k]),
      .bsh        (bsh_r[k][BPC-1:0]),
      .acc_next   (acc_nx_s[k]),
      .ashift_next(ashift_nx_s[k])
    );
  end

  assign last_s = (cnt_r == CW'(STEPS - 1));

  // Control FSM with lane registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      y_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        acc_r[k]    <= 8'h00;
        ashift_r[k] <= 8'h00;
        bsh_r[k]    <= 8'h00;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
              acc_r[k]    <= 8'h00;
              ashift_r[k] <= a[8*k +: 8];
              bsh_r[k]    <= b[8*k +: 8];
            end
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        RUN: begin
          for (int k = 0; k < LANES; k++) begin
            acc_r[k]    <= acc_nx_s[k];
            ashift_r[k] <= ashift_nx_s[k];
            bsh_r[k]    <= bsh_r[k] >> BPC;
          end
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            // The final step's sum is captured straight into y so DONE shows it at once.
            for (int k = 0; k < LANES; k++) begin
              y_r[8*k +: 8] <= acc_nx_s[k];
            end
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

endmodule
